dac_sample_sequencer: RTL



---
 rtl/dac_pkg.sv | 19 +
 rtl/sample_fifo.sv | 66 ++++++
 rtl/dac_sample_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC sample sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dac_pkg;

    // Sequencer operating states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRIME   = 2'd1,
        RUN     = 2'd2,
        STARVED = 2'd3
    } state_t;

    // Offset-binary zero level for a sample of data_size bits (data_size <= 64).
    function automatic logic [63:0] midscale(input int data_size);
        return 64'd1 << (data_size - 1);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with wrap-bit pointers for full/empty detection.
// Latency: a pushed word is visible at head_data the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module sample_fifo #(
    parameter int DATA_SIZE  = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [DATA_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_SIZE-1:0] head_data,
    output logic                 full,
    output logic                 empty,
    output logic [LW-1:0]        level
);

    logic [DATA_SIZE-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_SIZE-1:0] mem_d [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d;
    logic [AW:0]          rd_ptr_q, rd_ptr_d;
    logic                 push_ok;
    logic                 pop_ok;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level     = wr_ptr_q - rd_ptr_q;
    assign head_data = mem_q[rd_ptr_q[AW-1:0]];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;

    // Next pointer values and storage write.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers; resetting them discards any stored samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/dac_sample_sequencer.sv
// Paces buffered PCM samples to the modulator with a zero-order hold of osr_div+1 cycles.
// Latency: a sample popped on a tick appears on mod_data (with sample_strobe) one cycle later.
// Backpressure: s_ready drops only when the FIFO is full; prefill is allowed in every state.
module dac_sample_sequencer #(
    parameter int DATA_SIZE   = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int PRIME_LEVEL = 2,
    parameter int OSR_WIDTH   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [OSR_WIDTH-1:0]           osr_div,
    input  logic [DATA_SIZE-1:0]           s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [DATA_SIZE-1:0]           mod_data,
    output logic                           sample_strobe,
    output logic                           underrun,
    input  logic                           underrun_clr,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                           busy
);
    import dac_pkg::*;

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [DATA_SIZE-1:0] MIDSCALE  = DATA_SIZE'(midscale(DATA_SIZE));
    localparam logic [LW-1:0]        PRIME_LVL = LW'(PRIME_LEVEL);

    state_t               state_q, state_d;
    logic [OSR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_SIZE-1:0] mod_q, mod_d;
    logic                 strobe_q, strobe_d;
    logic                 under_q, under_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_SIZE-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LW-1:0]        fifo_lvl;
    logic                 tick;

    assign s_ready       = !fifo_full;
    assign fifo_push     = s_valid && !fifo_full;
    assign tick          = (cnt_q == osr_div);
    assign mod_data      = mod_q;
    assign sample_strobe = strobe_q;
    assign underrun      = under_q;
    assign fifo_level    = fifo_lvl;
    assign busy          = (state_q != IDLE);

    sample_fifo #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (s_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_lvl)
    );

    // Next-state, tick counter and output staging; underrun set beats clear.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mod_d    = mod_q;
        strobe_d = 1'b0;
        under_d  = under_q && !underrun_clr;
        fifo_pop = 1'b0;
        if (state_q != IDLE && !enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            mod_d   = MIDSCALE;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    mod_d = MIDSCALE;
                    if (enable) begin
                        state_d = PRIME;
                    end
                end
                PRIME: begin
                    cnt_d = '0;
                    mod_d = MIDSCALE;
                    if (fifo_lvl >= PRIME_LVL) begin
                        // Preload so the first RUN cycle is a tick.
                        state_d = RUN;
                        cnt_d   = osr_div;
                    end
                end
                RUN, STARVED: begin
                    // Counter free-runs through STARVED so the sample grid never slips.
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) begin
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            mod_d    = fifo_head;
                            strobe_d = 1'b1;
                            state_d  = RUN;
                        end else begin
                            under_d = 1'b1;
                            state_d = STARVED;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mod_q    <= MIDSCALE;
            strobe_q <= 1'b0;
            under_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mod_q    <= mod_d;
            strobe_q <= strobe_d;
            under_q  <= under_d;
        end
    end

endmodule
